// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : draw_sequencer
// Brief    : Clears a frame buffer, merges round-robin pixel streams into
//            buffer writes, stamps a frame-parity marker and hands off frames.
// Revision : 1.0
// ============================================================================
module draw_sequencer #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int NUM_STREAMS       = 2,
  parameter int COORD_WIDTH       = 8,
  parameter logic [BUFFER_DATA_WIDTH-1:0] CLEAR_COLOR = BUFFER_DATA_WIDTH'(12'h000)
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     draw_start,
  input  logic                                     draw_ack,
  input  logic                                     debug_mode,
  input  logic [NUM_STREAMS-1:0]                   pix_valid,
  output logic [NUM_STREAMS-1:0]                   pix_ready,
  input  logic [NUM_STREAMS-1:0]                   pix_last,
  input  logic [NUM_STREAMS-1:0]                   pix_covered,
  input  logic [NUM_STREAMS*COORD_WIDTH-1:0]       pix_x,
  input  logic [NUM_STREAMS*COORD_WIDTH-1:0]       pix_y,
  input  logic [NUM_STREAMS*BUFFER_DATA_WIDTH-1:0] pix_color,
  output logic                                     write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0]             write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0]             write_data,
  output logic                                     frame_done,
  output logic [15:0]                              frame_count
);

  localparam int c_sw = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam logic [BUFFER_ADDR_WIDTH-1:0] c_last_addr =
    BUFFER_ADDR_WIDTH'(BUFFER_WIDTH*BUFFER_HEIGHT-1);
  localparam logic [31:0] c_w = 32'(BUFFER_WIDTH);
  localparam logic [31:0] c_h = 32'(BUFFER_HEIGHT);
  localparam logic [c_sw:0] c_n = (c_sw+1)'(NUM_STREAMS);
  localparam logic [c_sw-1:0] c_last_stream = c_sw'(NUM_STREAMS-1);
  localparam logic [NUM_STREAMS-1:0] c_all = '1;
  localparam logic [BUFFER_DATA_WIDTH-1:0] c_mark_set =
    BUFFER_DATA_WIDTH'(4'hF) << (BUFFER_DATA_WIDTH-4);
  localparam logic [BUFFER_DATA_WIDTH-1:0] c_mark_clr = BUFFER_DATA_WIDTH'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_DRAW  = 3'd2,
    S_MARK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [BUFFER_ADDR_WIDTH-1:0]   r_clr_addr;
  logic [NUM_STREAMS-1:0]         r_finished;
  logic [c_sw-1:0]                r_ptr;
  logic                           r_debug;
  logic                           r_indicator;
  logic [15:0]                    r_frame_count;
  logic                           r_write_en;
  logic [BUFFER_ADDR_WIDTH-1:0]   r_write_addr;
  logic [BUFFER_DATA_WIDTH-1:0]   r_write_data;

  logic [COORD_WIDTH-1:0]         w_x     [NUM_STREAMS];
  logic [COORD_WIDTH-1:0]         w_y     [NUM_STREAMS];
  logic [BUFFER_DATA_WIDTH-1:0]   w_color [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]         w_req;
  logic [NUM_STREAMS-1:0]         w_rot;
  logic [c_sw-1:0]                w_off;
  logic [c_sw:0]                  w_sum;
  logic [c_sw-1:0]                w_grant;
  logic                           w_accept;
  logic                           w_in_range;
  logic                           w_enter_clear;
  logic [BUFFER_ADDR_WIDTH-1:0]   w_pix_addr;
  logic [BUFFER_DATA_WIDTH-1:0]   w_tint;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_unpack
    assign w_x[i]     = pix_x[i*COORD_WIDTH +: COORD_WIDTH];
    assign w_y[i]     = pix_y[i*COORD_WIDTH +: COORD_WIDTH];
    assign w_color[i] = pix_color[i*BUFFER_DATA_WIDTH +: BUFFER_DATA_WIDTH];
  end

  // Rotate requests so the priority stream sits at bit 0; lowest set bit wins.
  always_comb begin
    w_req = pix_valid & ~r_finished;
    w_rot = NUM_STREAMS'({w_req, w_req} >> r_ptr);
    w_off = '0;
    for (int k = NUM_STREAMS-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = c_sw'(k);
    end
    w_sum    = (c_sw+1)'(r_ptr) + (c_sw+1)'(w_off);
    w_grant  = (w_sum >= c_n) ? c_sw'(w_sum - c_n) : c_sw'(w_sum);
    w_accept = (r_state == S_DRAW) && (|w_req);
    pix_ready = '0;
    if (r_state == S_DRAW) begin
      pix_ready = w_accept ? (NUM_STREAMS'(1) << w_grant) : ~r_finished;
    end
  end

  always_comb begin
    w_in_range = (32'(w_x[w_grant]) < c_w) && (32'(w_y[w_grant]) < c_h);
    w_pix_addr = BUFFER_ADDR_WIDTH'(32'(w_x[w_grant]) + 32'(w_y[w_grant]) * c_w);
    w_tint     = BUFFER_DATA_WIDTH'(32'(w_grant) + 32'd1) << (BUFFER_DATA_WIDTH-4);
  end

  always_comb begin
    w_next        = r_state;
    w_enter_clear = 1'b0;
    case (r_state)
      S_IDLE:  if (draw_start) begin
                 w_next        = S_CLEAR;
                 w_enter_clear = 1'b1;
               end
      S_CLEAR: if (r_clr_addr == c_last_addr) w_next = S_DRAW;
      S_DRAW:  if (r_finished == c_all) w_next = S_MARK;
      S_MARK:  w_next = S_DONE;
      S_DONE:  if (draw_ack) begin
                 w_next        = S_CLEAR;
                 w_enter_clear = 1'b1;
               end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clr_addr    <= '0;
      r_finished    <= '0;
      r_ptr         <= '0;
      r_debug       <= 1'b0;
      r_indicator   <= 1'b0;
      r_frame_count <= '0;
      r_write_en    <= 1'b0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
    end else begin
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      if (w_enter_clear) begin
        r_finished <= '0;
        r_ptr      <= '0;
        r_clr_addr <= '0;
        r_debug    <= debug_mode;
      end
      case (r_state)
        S_CLEAR: begin
          r_write_en   <= 1'b1;
          r_write_addr <= r_clr_addr;
          r_write_data <= CLEAR_COLOR;
          r_clr_addr   <= r_clr_addr + 1'b1;
        end
        S_DRAW: if (w_accept) begin
          if (pix_covered[w_grant] && w_in_range) begin
            r_write_en   <= 1'b1;
            r_write_addr <= w_pix_addr;
            r_write_data <= r_debug ? w_tint : w_color[w_grant];
          end
          if (pix_last[w_grant]) r_finished[w_grant] <= 1'b1;
          r_ptr <= (w_grant == c_last_stream) ? '0 : w_grant + 1'b1;
        end
        S_MARK: begin
          r_write_en    <= 1'b1;
          r_write_addr  <= c_last_addr;
          r_write_data  <= r_indicator ? c_mark_set : c_mark_clr;
          r_indicator   <= ~r_indicator;
          r_frame_count <= r_frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign write_en    = r_write_en;
  assign write_addr  = r_write_addr;
  assign write_data  = r_write_data;
  assign frame_done  = (r_state == S_DONE);
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sequencer
// Brief    : Randomized scoreboard bench for draw_sequencer on a 4x2 buffer.
// Revision : 1.0
// ============================================================================
module tb_draw_sequencer;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic        cov;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        draw_start, draw_ack, debug_mode;
  logic [1:0]  pix_valid, pix_ready, pix_last, pix_covered;
  logic [15:0] pix_x, pix_y;
  logic [23:0] pix_color;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [11:0] write_data;
  logic        frame_done;
  logic [15:0] frame_count;

  logic [7:0]  sx [2];
  logic [7:0]  sy [2];
  logic [11:0] sc [2];

  assign pix_x     = {sx[1], sx[0]};
  assign pix_y     = {sy[1], sy[0]};
  assign pix_color = {sc[1], sc[0]};

  draw_sequencer #(
    .BUFFER_WIDTH(4), .BUFFER_HEIGHT(2), .BUFFER_DATA_WIDTH(12),
    .BUFFER_ADDR_WIDTH(3), .NUM_STREAMS(2), .COORD_WIDTH(8),
    .CLEAR_COLOR(12'h000)
  ) dut (
    .clk(clk), .rstn(rstn), .draw_start(draw_start), .draw_ack(draw_ack),
    .debug_mode(debug_mode), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .pix_covered(pix_covered), .pix_x(pix_x),
    .pix_y(pix_y), .pix_color(pix_color), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    hs_count = 0;
  beat_t bq0[$];
  beat_t bq1[$];
  wr_t   exp_q[$];
  logic [1:0]  fin_model = 2'b00;
  int          ptr_model = 0;
  logic        debug_model = 1'b0;
  logic        ind_model = 1'b0;
  logic [15:0] fc_model = 16'd0;
  bit          gappy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int s, input int x, input int y, input int c,
                          input bit cov, input bit last);
    beat_t b;
    b.x = 8'(x); b.y = 8'(y); b.c = 12'(c); b.cov = cov; b.last = last;
    if (s == 0) bq0.push_back(b); else bq1.push_back(b);
  endtask

  task automatic add_random(input int s, input int n);
    for (int i = 0; i < n; i++)
      add_beat(s, $urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 4095),
               $urandom_range(0, 3) != 0, i == n-1);
  endtask

  // Expected contents of a new frame: full clear sweep, fresh arbitration.
  task automatic begin_frame_model(input logic dbg);
    for (int a = 0; a < 8; a++) begin
      wr_t w;
      w.addr = 3'(a); w.data = 12'h000;
      exp_q.push_back(w);
    end
    fin_model   = 2'b00;
    ptr_model   = 0;
    debug_model = dbg;
  endtask

  // Input driver: present each stream's head beat, optionally with idle gaps.
  initial begin
    pix_valid = '0; pix_last = '0; pix_covered = '0;
    for (int s = 0; s < 2; s++) begin sx[s] = '0; sy[s] = '0; sc[s] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        beat_t b;
        bit    have;
        have = (s == 0) ? (bq0.size() > 0) : (bq1.size() > 0);
        b = '0;
        if (have) b = (s == 0) ? bq0[0] : bq1[0];
        if (have && (!gappy || $urandom_range(0, 3) != 0)) begin
          pix_valid[s] = 1'b1; pix_last[s] = b.last; pix_covered[s] = b.cov;
          sx[s] = b.x; sy[s] = b.y; sc[s] = b.c;
        end else begin
          pix_valid[s] = 1'b0;
        end
      end
    end
  end

  // Monitor: score bus writes, arbitration, and turn accepted beats into expectations.
  always @(negedge clk) begin
    if (rstn) begin
      logic [1:0] hs, req;
      int g, s;
      if (write_en) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write at %0t",
                   write_addr, write_data, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(write_addr), 32'(e.addr));
          check("write_data", 32'(write_data), 32'(e.data));
        end
      end else begin
        check("idle_bus", 32'({write_addr, write_data}), 32'd0);
      end
      check("ready_finished", 32'(pix_ready & fin_model), 32'd0);
      req = pix_valid & ~fin_model;
      if ((|pix_ready) && (req != 2'b00)) begin
        g = req[ptr_model] ? ptr_model : 1 - ptr_model;
        check("grant", 32'(pix_ready), 32'(1 << g));
      end
      hs = pix_valid & pix_ready;
      if (hs == 2'b01 || hs == 2'b10) begin
        beat_t b;
        s = hs[1] ? 1 : 0;
        if ((s == 0 && bq0.size() == 0) || (s == 1 && bq1.size() == 0)) begin
          n_tests++; n_fail++;
          $display("FAIL stray_accept: got handshake on stream %0d, required none", s);
        end else begin
          b = (s == 0) ? bq0.pop_front() : bq1.pop_front();
          if (b.cov && b.x < 8'd4 && b.y < 8'd2) begin
            wr_t w;
            w.addr = 3'(b.x + b.y * 8'd4);
            w.data = debug_model ? 12'((s + 1) << 8) : b.c;
            exp_q.push_back(w);
          end
          ptr_model = 1 - s;
          if (b.last) fin_model[s] = 1'b1;
          if (fin_model == 2'b11) begin
            wr_t m;
            m.addr = 3'd7;
            m.data = ind_model ? 12'hF00 : 12'h00F;
            ind_model = ~ind_model;
            exp_q.push_back(m);
          end
          hs_count++;
        end
      end
    end
  end

  task automatic finish_frame();
    int k = 0;
    while (!frame_done && k < 300) begin @(negedge clk); k++; end
    check("frame_done_seen", 32'(frame_done), 32'd1);
    fc_model++;
    check("frame_count", 32'(frame_count), 32'(fc_model));
    for (int i = 0; i < 5; i++) begin
      draw_start = (i == 1);
      @(negedge clk);
      check("frame_done_hold", 32'(frame_done), 32'd1);
    end
    draw_start = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic ack_frame(input logic dbg);
    draw_ack = 1'b1; debug_mode = dbg;
    begin_frame_model(dbg);
    @(negedge clk);
    draw_ack = 1'b0; debug_mode = ~dbg;
    check("frame_done_released", 32'(frame_done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write_en"},    32'(write_en), 32'd0);
    check({tag, "_write_addr"},  32'(write_addr), 32'd0);
    check({tag, "_write_data"},  32'(write_data), 32'd0);
    check({tag, "_pix_ready"},   32'(pix_ready), 32'd0);
    check({tag, "_frame_done"},  32'(frame_done), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    int k;
    rstn = 1'b0; draw_start = 1'b0; draw_ack = 1'b0; debug_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 1: colour mode, both streams continuously valid.
    add_beat(0, 1, 0, 12'h123, 1, 0);
    add_beat(0, 3, 1, 12'hABC, 1, 0);
    add_beat(0, 2, 1, 12'h555, 1, 1);
    add_beat(1, 0, 1, 12'h0F0, 1, 0);
    add_beat(1, 1, 1, 12'hAAA, 1, 0);
    add_beat(1, 3, 0, 12'hF0F, 1, 1);
    draw_start = 1'b1; debug_mode = 1'b0;
    begin_frame_model(1'b0);
    @(negedge clk);
    draw_start = 1'b0; debug_mode = 1'b1;
    k = 1;
    while (!(|pix_ready) && k < 50) begin @(negedge clk); k++; end
    check("clear_latency", 32'(k), 32'd9);
    finish_frame();

    // Frame 2: tint mode, out-of-range and uncovered-last on stream 0.
    add_beat(0, 3, 1, 12'hABC, 1, 0);
    add_beat(0, 4, 0, 12'h111, 1, 0);
    add_beat(0, 2, 0, 12'h222, 0, 1);
    add_random(1, 5);
    ack_frame(1'b1);
    finish_frame();

    // Frame 3: gappy random traffic, abandoned by reset mid-draw.
    gappy = 1'b1;
    add_random(0, 8);
    add_random(1, 8);
    hs_count = 0;
    ack_frame(1'($urandom_range(0, 1)));
    k = 0;
    while (hs_count < 3 && k < 200) begin @(negedge clk); k++; end
    check("draw_reached", 32'(hs_count >= 3), 32'd1);
    @(posedge clk); #3 rstn = 1'b0;
    #1 check_all_zero("mid_draw_reset");
    bq0.delete(); bq1.delete(); exp_q.delete();
    fin_model = 2'b00; ptr_model = 0; ind_model = 1'b0; fc_model = 16'd0;
    @(negedge clk); rstn = 1'b1;
    repeat (10) @(negedge clk);

    // Frame 4: fresh start after reset; marker and counter restart.
    add_random(0, 4);
    add_random(1, 4);
    draw_start = 1'b1; debug_mode = 1'($urandom_range(0, 1));
    begin_frame_model(debug_mode);
    @(negedge clk);
    draw_start = 1'b0; debug_mode = ~debug_mode;
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter BUFFER_WIDTH, default 160, frame buffer width in pixels.
REQ-002 SHALL have parameter BUFFER_HEIGHT, default 120, frame buffer height in pixels.
REQ-003 SHALL have parameter BUFFER_DATA_WIDTH, default 12, pixel colour width (RGB444 at default).
REQ-004 SHALL have parameter BUFFER_ADDR_WIDTH, default $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), write address width.
REQ-005 SHALL have parameter NUM_STREAMS, default 2, number of pixel input streams; legal range 1..15.
REQ-006 SHALL have parameter COORD_WIDTH, default 8, width of each x and y coordinate.
REQ-007 SHALL have parameter CLEAR_COLOR, default 12'h000, colour written during clear.
REQ-008 SHALL have ports: clk input 1, system clock; rstn input 1, asynchronous active-low reset.
REQ-009 SHALL have ports: draw_start input 1, begin first frame; draw_ack input 1, consumer accepted completed frame.
REQ-010 SHALL have port: debug_mode input 1, 0 = pixel colour, 1 = stream-ID tint.
REQ-011 SHALL have ports: pix_valid input NUM_STREAMS; pix_ready output NUM_STREAMS; pix_last input NUM_STREAMS; pix_covered input NUM_STREAMS.
REQ-012 SHALL have ports: pix_x, pix_y input NUM_STREAMS*COORD_WIDTH; pix_color input NUM_STREAMS*BUFFER_DATA_WIDTH; stream i occupies slice i.
REQ-013 SHALL have ports: write_en output 1; write_addr output BUFFER_ADDR_WIDTH; write_data output BUFFER_DATA_WIDTH; frame_done output 1; frame_count output 16.

Function
REQ-014 SHALL implement states IDLE, CLEAR, DRAW, MARK, DONE; reset state IDLE.
REQ-015 IDLE: draw_start=1 -> CLEAR; draw_start ignored in all other states.
REQ-016 CLEAR: write CLEAR_COLOR to addresses 0..W*H-1, one per cycle, ascending; after address W*H-1 -> DRAW; exactly W*H write cycles.
REQ-017 DRAW: pix_ready[i]=1 only for streams whose last flag not yet seen this frame; pix_ready=0 in all other states.
REQ-018 DRAW: round-robin arbitration among streams with valid&ready; at most one beat accepted per cycle; priority pointer moves to grantee+1 (mod NUM_STREAMS) after each grant; pix_ready of non-granted streams SHALL be 0 that cycle.
REQ-019 Accepted beat with covered=1 and x<BUFFER_WIDTH and y<BUFFER_HEIGHT -> write one cycle later: addr = x + y*BUFFER_WIDTH, data per REQ-020.
REQ-020 write_data: debug_mode latched 0 -> pix_color[i]; latched 1 -> (i+1) placed in top 4 bits, remaining bits 0 (stream 0 -> 12'h100, stream 1 -> 12'h200 at default).
REQ-021 Beats with covered=0 or out-of-range coordinates SHALL produce no write but SHALL still honour last.
REQ-022 Accepted beat with last=1 SHALL mark its stream finished; when all NUM_STREAMS are finished -> MARK (after the final pixel write has issued).
REQ-023 MARK: one cycle; write addr W*H-1, data 12'hF00 if indicator=1 else 12'h00F; indicator toggles.
REQ-024 DONE: frame_done=1 (level) until draw_ack; frame_count increments by 1 (wraps at 16'hFFFF) on MARK->DONE; draw_ack=1 in DONE -> CLEAR next cycle.
REQ-025 debug_mode SHALL be sampled only on IDLE->CLEAR and DONE->CLEAR; stable for the whole frame.
REQ-026 Finished flags and arbitration pointer SHALL clear on entry to CLEAR.
REQ-027 write_en, write_addr, write_data SHALL be registered; write_addr/write_data = 0 when write_en=0.

Reset
REQ-028 rstn low SHALL asynchronously force: state IDLE, write_en 0, write_addr 0, write_data 0, pix_ready 0, frame_done 0, frame_count 0, indicator 0, debug latch 0, pointer 0, finished flags 0.
REQ-029 Reset mid-CLEAR or mid-DRAW SHALL abandon the frame; no write after rstn deasserts until draw_start.

Verification
REQ-030 W=4,H=2: draw_start pulse -> 8 consecutive writes addr 0..7 data 12'h000, then pix_ready asserted.
REQ-031 Both streams valid continuously, 3 beats each -> grants alternate 0,1,0,1,0,1; no cycle with two ready bits high.
REQ-032 Stream 0 beat x=3,y=1,color 12'hABC, covered=1 (W=4) -> write_en one cycle later, addr 7, data 12'hABC; debug_mode=1 -> data 12'h100.
REQ-033 Beat x=4,y=0 (W=4) or covered=0 with last=1 -> no write; stream ready drops; other stream still served.
REQ-034 Both streams last -> MARK write addr W*H-1 data 12'h00F, frame_done held 5 cycles until draw_ack, frame_count=1; second frame MARK data 12'hF00, frame_count=2.
REQ-035 rstn low during DRAW -> all outputs zero immediately; no writes until next draw_start.
